fwid_read_ctrl: RTL and testbench

Controller that sequences the 64x1 firmware-ID ROM and shares the result between two requesters. On the first request, and after every refresh, it walks ROM addresses 0..63 and assembles the 64-bit firmware ID. Later requests are served from the cached word. It sits between the ROM and the housekeeping packet builder / slow-control register file, so neither client drives the ROM address directly.

---
 rtl/fwid_pkg.sv | 8 +
 rtl/fwid_rr_arb.sv | 13 +
 rtl/fwid_read_ctrl.sv | 74 +++++++
 tb/tb_fwid_read_ctrl.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/fwid_pkg.sv
// fwid_pkg: shared widths and FSM state encodings for the firmware-ID read controller.
package fwid_pkg;
  localparam int FWID_W = 64;
  localparam int FWID_AW = 6;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] FETCH = 2'd1;
  localparam logic [1:0] ACK = 2'd2;
endpackage

// File: rtl/fwid_rr_arb.sv
// fwid_rr_arb: 2-way round-robin arbiter; the pointer's requester wins, else the other one.
module fwid_rr_arb (
  input  logic [1:0] req,
  input  logic       ptr,
  input  logic       enable,
  output logic [1:0] grant
);
  always_comb begin
    grant = !enable ? 2'b00 :
            req[ptr] ? (ptr ? 2'b10 : 2'b01) :
            req[~ptr] ? (ptr ? 2'b01 : 2'b10) : 2'b00;
  end
endmodule

// File: rtl/fwid_read_ctrl.sv
// fwid_read_ctrl: walks the 64x1 firmware-ID ROM once per refresh and serves the cached word to two requesters.
module fwid_read_ctrl #(
  parameter int NREQ = 2,
  parameter int FWID_W = fwid_pkg::FWID_W,
  parameter int FWID_AW = fwid_pkg::FWID_AW
) (
  input  logic               clk,
  input  logic               rst,
  output logic [FWID_AW-1:0] rom_addr,
  input  logic               rom_data,
  input  logic [NREQ-1:0]    req,
  output logic [NREQ-1:0]    ack,
  output logic [FWID_W-1:0]  id_word,
  output logic               id_valid,
  input  logic               refresh,
  output logic               busy
);
  import fwid_pkg::*;
  logic [1:0] state;
  logic ptr, pending, any_req;
  logic [NREQ-1:0] grant;
  assign any_req = |req;
  assign busy = (state == FETCH);
  fwid_rr_arb u_arb (
    .req(req),
    .ptr(ptr),
    .enable(state != ACK),
    .grant(grant)
  );
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      rom_addr <= '0;
      ack <= '0;
      id_word <= '0;
      id_valid <= 1'b0;
      ptr <= 1'b0;
      pending <= 1'b0;
    end else begin
      case (state)
        IDLE:
          if (refresh || pending || (any_req && !id_valid)) begin
            state <= FETCH;
            rom_addr <= '0;
            id_valid <= 1'b0;
            pending <= 1'b0;
          end else if (any_req) begin
            state <= ACK;
            ack <= grant;
          end
        FETCH: begin
          id_word[rom_addr] <= rom_data;
          if (refresh) rom_addr <= '0;
          else if (rom_addr == FWID_AW'(FWID_W - 1)) begin
            rom_addr <= '0;
            id_valid <= 1'b1;
            state <= any_req ? ACK : IDLE;
            ack <= grant;
          end else rom_addr <= rom_addr + 1'b1;
        end
        ACK: begin
          // a refresh here must not disturb the word the current holder is reading
          if (refresh) pending <= 1'b1;
          if (!(|(ack & req))) begin
            ack <= '0;
            ptr <= ~ptr;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fwid_read_ctrl.sv
// tb_fwid_read_ctrl: directed and randomized checks of the firmware-ID controller against a transaction-level model.
module tb_fwid_read_ctrl;
  logic clk = 0, rst = 0;
  logic [5:0] rom_addr;
  logic rom_data;
  logic [1:0] req = 2'b00, ack;
  logic [63:0] id_word;
  logic id_valid, busy;
  logic refresh = 0;
  logic [63:0] rom_img = 64'h1234DEADBEEF5678;
  logic [63:0] old_word;
  int compared = 0, mismatched = 0;
  logic ptr_m = 0;
  bit valid_m = 0;

  assign rom_data = rom_img[rom_addr];
  always #5 clk = ~clk;

  fwid_read_ctrl dut (
    .clk(clk), .rst(rst), .rom_addr(rom_addr), .rom_data(rom_data),
    .req(req), .ack(ack), .id_word(id_word), .id_valid(id_valid),
    .refresh(refresh), .busy(busy)
  );

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic serve(input logic [1:0] r, input bit do_ref, input logic [63:0] img);
    int lat, n, hold;
    logic first;
    logic [1:0] g;
    if (do_ref) rom_img = img;
    lat = (do_ref || !valid_m) ? 65 : 1;
    first = r[ptr_m] ? ptr_m : ~ptr_m;
    g = first ? 2'b10 : 2'b01;
    req = r;
    refresh = do_ref;
    n = 0;
    do begin
      step();
      refresh = 0;
      n++;
      if (ack == 2'b00 && n <= 64) begin
        chk("busy_walk", {63'b0, busy}, 64'd1);
        chk("addr_walk", {58'b0, rom_addr}, 64'(n - 1));
      end
    end while (ack == 2'b00 && n < 80);
    chk("ack_latency", 64'(n), 64'(lat));
    chk("ack_grant", {62'b0, ack}, {62'b0, g});
    chk("id_word", id_word, rom_img);
    chk("id_valid", {63'b0, id_valid}, 64'd1);
    chk("busy_in_ack", {63'b0, busy}, 64'd0);
    chk("addr_in_ack", {58'b0, rom_addr}, 64'd0);
    valid_m = 1;
    hold = $urandom_range(0, 3);
    repeat (hold) begin
      step();
      chk("ack_hold", {62'b0, ack}, {62'b0, g});
    end
    req[first] = 1'b0;
    step();
    chk("ack_release", {62'b0, ack}, 64'd0);
    ptr_m = ~ptr_m;
    if (r == 2'b11) begin
      step();
      chk("ack_second", {62'b0, ack}, {62'b0, ~g});
      chk("id_word_second", id_word, rom_img);
      req = 2'b00;
      step();
      chk("ack_release2", {62'b0, ack}, 64'd0);
      ptr_m = ~ptr_m;
    end
    req = 2'b00;
    step();
  endtask

  initial begin
    #2 rst = 1;
    step();
    chk("rst_ack", {62'b0, ack}, 64'd0);
    chk("rst_word", id_word, 64'd0);
    chk("rst_valid", {63'b0, id_valid}, 64'd0);
    chk("rst_busy", {63'b0, busy}, 64'd0);
    chk("rst_addr", {58'b0, rom_addr}, 64'd0);
    rst = 0;
    step();
    // first request misses, then a cache hit from the other requester, then a simultaneous pair
    serve(2'b01, 0, 64'd0);
    chk("first_word", id_word, 64'h1234DEADBEEF5678);
    serve(2'b10, 0, 64'd0);
    serve(2'b11, 0, 64'd0);
    // refresh mid-walk at address 30 restarts from 0
    rom_img = 64'hFFFF0000AAAA5555;
    refresh = 1;
    step();
    refresh = 0;
    chk("ref_busy", {63'b0, busy}, 64'd1);
    chk("ref_valid", {63'b0, id_valid}, 64'd0);
    chk("ref_addr0", {58'b0, rom_addr}, 64'd0);
    repeat (30) step();
    chk("ref_addr30", {58'b0, rom_addr}, 64'd30);
    refresh = 1;
    req = 2'b10;
    step();
    refresh = 0;
    chk("restart_addr", {58'b0, rom_addr}, 64'd0);
    chk("restart_valid", {63'b0, id_valid}, 64'd0);
    repeat (63) step();
    chk("restart_addr63", {58'b0, rom_addr}, 64'd63);
    chk("restart_noack", {62'b0, ack}, 64'd0);
    step();
    chk("restart_ack", {62'b0, ack}, 64'd2);
    chk("restart_word", id_word, 64'hFFFF0000AAAA5555);
    req = 2'b00;
    step();
    chk("restart_rel", {62'b0, ack}, 64'd0);
    ptr_m = ~ptr_m;
    valid_m = 1;
    // refresh during a grant: holder keeps the old word, walk follows
    req = 2'b01;
    step();
    chk("hit_ack", {62'b0, ack}, 64'd1);
    old_word = rom_img;
    rom_img = {$urandom, $urandom};
    refresh = 1;
    step();
    refresh = 0;
    repeat (2) begin
      chk("ackref_ack", {62'b0, ack}, 64'd1);
      chk("ackref_word", id_word, old_word);
      chk("ackref_valid", {63'b0, id_valid}, 64'd1);
      step();
    end
    req = 2'b00;
    step();
    chk("ackref_rel", {62'b0, ack}, 64'd0);
    chk("ackref_idle", {63'b0, busy}, 64'd0);
    ptr_m = ~ptr_m;
    step();
    chk("ackref_fetch", {63'b0, busy}, 64'd1);
    chk("ackref_invalid", {63'b0, id_valid}, 64'd0);
    repeat (63) step();
    step();
    chk("ackref_done", {63'b0, busy}, 64'd0);
    chk("ackref_newword", id_word, rom_img);
    chk("ackref_newvalid", {63'b0, id_valid}, 64'd1);
    // asynchronous reset at walk address 40
    refresh = 1;
    step();
    refresh = 0;
    repeat (40) step();
    chk("pre_rst_addr", {58'b0, rom_addr}, 64'd40);
    #2 rst = 1;
    #1;
    chk("arst_addr", {58'b0, rom_addr}, 64'd0);
    chk("arst_busy", {63'b0, busy}, 64'd0);
    chk("arst_word", id_word, 64'd0);
    chk("arst_valid", {63'b0, id_valid}, 64'd0);
    chk("arst_ack", {62'b0, ack}, 64'd0);
    step();
    rst = 0;
    valid_m = 0;
    ptr_m = 0;
    step();
    serve(2'b01, 0, 64'd0);
    repeat (12) begin
      logic [1:0] r;
      bit d;
      r = 2'($urandom_range(1, 3));
      d = ($urandom_range(0, 2) == 0);
      serve(r, d, {$urandom, $urandom});
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
